// File: rtl/riscv_wb_arb2.sv
// Two-master (instruction/data) to one-slave classic Wishbone arbiter with
// fixed data priority or round-robin grant, plus a bus-timeout watchdog.
module riscv_wb_arb2 #(
  parameter int unsigned DPRIO   = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [31:0] m0_adr_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_rr_last;
  logic          r_rr_seen;
  logic [CW-1:0] r_tmo_cnt;
  logic          w_gnt;
  logic          w_resp;
  logic          w_tmo;
  logic          w_pick_d;

  assign w_gnt  = (r_state != IDLE);
  assign w_resp = s_ack_i | s_err_i;
  // A response in the timeout cycle wins over the watchdog.
  assign w_tmo  = (TIMEOUT != 0) && w_gnt && !w_resp && (r_tmo_cnt == CW'(TIMEOUT));

  // rr_last resets to 0 but no master has been granted yet, so the first
  // round-robin conflict must go to M0; r_rr_seen tracks that case.
  assign w_pick_d = (DPRIO != 0) || (r_rr_seen && !r_rr_last);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) w_next = w_pick_d ? GNT_D : GNT_I;
        else if (m0_cyc_i)        w_next = GNT_I;
        else if (m1_cyc_i)        w_next = GNT_D;
      end
      GNT_I:   if (!m0_cyc_i || w_tmo) w_next = IDLE;
      GNT_D:   if (!m1_cyc_i || w_tmo) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_rr_last <= 1'b0;
      r_rr_seen <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == GNT_I) begin
        r_rr_last <= 1'b0;
        r_rr_seen <= 1'b1;
      end else if (r_state == IDLE && w_next == GNT_D) begin
        r_rr_last <= 1'b1;
        r_rr_seen <= 1'b1;
      end
      if (r_state == IDLE || w_resp || w_tmo) r_tmo_cnt <= '0;
      else if (s_stb_o && TIMEOUT != 0)       r_tmo_cnt <= r_tmo_cnt + CW'(1);
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (r_state)
      GNT_I: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_sel_o = '1;
        s_adr_o = m0_adr_i;
      end
      GNT_D: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign m0_ack_o = s_ack_i & (r_state == GNT_I) & m0_stb_i;
  assign m1_ack_o = s_ack_i & (r_state == GNT_D) & m1_stb_i;
  assign m0_err_o = (s_err_i & (r_state == GNT_I) & m0_stb_i) | (w_tmo & (r_state == GNT_I));
  assign m1_err_o = (s_err_i & (r_state == GNT_D) & m1_stb_i) | (w_tmo & (r_state == GNT_D));

  // Read data is held at 0 while reset is asserted.
  assign m0_dat_o = rst_n_i ? s_dat_i : '0;
  assign m1_dat_o = rst_n_i ? s_dat_i : '0;

endmodule

// File: tb/tb_riscv_wb_arb2.sv
// Bench for riscv_wb_arb2: instance 0 uses data priority, instance 1 round-robin;
// an owner/countdown model is compared on every falling edge, plus directed literals.
module tb_riscv_wb_arb2;

  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [2];
  logic        m0_cyc [2];
  logic        m0_stb [2];
  logic [31:0] m0_adr [2];
  logic [31:0] m0_dat [2];
  logic        m0_ack [2];
  logic        m0_err [2];
  logic        m1_cyc [2];
  logic        m1_stb [2];
  logic        m1_we  [2];
  logic [3:0]  m1_sel [2];
  logic [31:0] m1_adr [2];
  logic [31:0] m1_wdat[2];
  logic [31:0] m1_dat [2];
  logic        m1_ack [2];
  logic        m1_err [2];
  logic        s_cyc  [2];
  logic        s_stb  [2];
  logic        s_we   [2];
  logic [3:0]  s_sel  [2];
  logic [31:0] s_adr  [2];
  logic [31:0] s_wdat [2];
  logic [31:0] s_rdat [2];
  logic        s_ack  [2];
  logic        s_err  [2];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    riscv_wb_arb2 #(.DPRIO(g == 0 ? 1 : 0), .TIMEOUT(TMO)) u_dut (
      .clk_i   (clk),
      .rst_n_i (rst_n[g]),
      .m0_cyc_i(m0_cyc[g]),
      .m0_stb_i(m0_stb[g]),
      .m0_adr_i(m0_adr[g]),
      .m0_dat_o(m0_dat[g]),
      .m0_ack_o(m0_ack[g]),
      .m0_err_o(m0_err[g]),
      .m1_cyc_i(m1_cyc[g]),
      .m1_stb_i(m1_stb[g]),
      .m1_we_i (m1_we[g]),
      .m1_sel_i(m1_sel[g]),
      .m1_adr_i(m1_adr[g]),
      .m1_dat_i(m1_wdat[g]),
      .m1_dat_o(m1_dat[g]),
      .m1_ack_o(m1_ack[g]),
      .m1_err_o(m1_err[g]),
      .s_cyc_o (s_cyc[g]),
      .s_stb_o (s_stb[g]),
      .s_we_o  (s_we[g]),
      .s_sel_o (s_sel[g]),
      .s_adr_o (s_adr[g]),
      .s_dat_o (s_wdat[g]),
      .s_dat_i (s_rdat[g]),
      .s_ack_i (s_ack[g]),
      .s_err_i (s_err[g])
    );
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, exp);
    end
  endtask

  // Model: owner (-1 none, 0 instr, 1 data), last granted, cycles of unanswered strobe.
  int own  [2] = '{-1, -1};
  int last [2] = '{-1, -1};
  int cnt  [2] = '{0, 0};

  task automatic model_step(input int d);
    bit tmo, ec, es, ew, a0, r0, a1, r1;
    logic [3:0]  esel;
    logic [31:0] ea, ewd, erd;
    tmo = 0; ec = 0; es = 0; ew = 0; a0 = 0; r0 = 0; a1 = 0; r1 = 0;
    esel = '0; ea = '0; ewd = '0;
    erd = rst_n[d] ? s_rdat[d] : 32'h0;
    if (!rst_n[d]) begin
      own[d] = -1; last[d] = -1; cnt[d] = 0;
    end else if (own[d] >= 0) begin
      tmo = (cnt[d] == TMO) && !s_ack[d] && !s_err[d];
      if (own[d] == 0) begin
        ec = m0_cyc[d]; es = m0_stb[d]; esel = 4'hF; ea = m0_adr[d];
        a0 = s_ack[d] && m0_stb[d];
        r0 = (s_err[d] && m0_stb[d]) || tmo;
      end else begin
        ec = m1_cyc[d]; es = m1_stb[d]; ew = m1_we[d]; esel = m1_sel[d];
        ea = m1_adr[d]; ewd = m1_wdat[d];
        a1 = s_ack[d] && m1_stb[d];
        r1 = (s_err[d] && m1_stb[d]) || tmo;
      end
    end
    chk("s_ctl", d, 32'({s_cyc[d], s_stb[d], s_we[d], s_sel[d]}), 32'({ec, es, ew, esel}));
    chk("s_adr", d, s_adr[d], ea);
    chk("s_dat_o", d, s_wdat[d], ewd);
    chk("m_resp", d, 32'({m0_ack[d], m0_err[d], m1_ack[d], m1_err[d]}), 32'({a0, r0, a1, r1}));
    chk("m0_dat", d, m0_dat[d], erd);
    chk("m1_dat", d, m1_dat[d], erd);
    if (rst_n[d]) begin
      if (own[d] < 0) begin
        if (m0_cyc[d] && m1_cyc[d]) own[d] = (d == 0 || last[d] == 0) ? 1 : 0;
        else if (m0_cyc[d])         own[d] = 0;
        else if (m1_cyc[d])         own[d] = 1;
        if (own[d] >= 0) last[d] = own[d];
        cnt[d] = 0;
      end else if (!ec || tmo) begin
        own[d] = -1; cnt[d] = 0;
      end else if (s_ack[d] || s_err[d]) begin
        cnt[d] = 0;
      end else if (es) begin
        cnt[d]++;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input int d, input bit c, input bit s, input logic [31:0] a);
    m0_cyc[d] = c; m0_stb[d] = s; m0_adr[d] = a;
  endtask

  task automatic set_m1(input int d, input bit c, input bit s, input bit we,
                        input logic [3:0] sel, input logic [31:0] a, input logic [31:0] dat);
    m1_cyc[d] = c; m1_stb[d] = s; m1_we[d] = we; m1_sel[d] = sel; m1_adr[d] = a; m1_wdat[d] = dat;
  endtask

  task automatic set_sl(input int d, input bit ack, input bit err, input logic [31:0] dat);
    s_ack[d] = ack; s_err[d] = err; s_rdat[d] = dat;
  endtask

  initial begin
    int n;
    logic [31:0] got [3];
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      set_m0(d, 0, 0, 0);
      set_m1(d, 0, 0, 0, 0, 0, 0);
      set_sl(d, 0, 0, 32'hA5A5_A5A5);
    end
    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_s_cyc", d, 32'(s_cyc[d]), 0);
      chk("rst_m0_dat", d, m0_dat[d], 0);
      rst_n[d] = 1'b1;
    end
    tick();

    // 1: instruction read, slave acks 2 cycles after strobe
    set_sl(0, 0, 0, 0);
    set_m0(0, 1, 1, 32'h100); tick();
    chk("t1_s_adr", 0, s_adr[0], 32'h100);
    chk("t1_s_sel", 0, 32'(s_sel[0]), 32'hF);
    tick(); tick();
    set_sl(0, 1, 0, 32'h13); #1;
    chk("t1_m0_ack", 0, 32'(m0_ack[0]), 1);
    chk("t1_m0_dat", 0, m0_dat[0], 32'h13);
    chk("t1_m1_ack", 0, 32'(m1_ack[0]), 0);
    tick(); set_sl(0, 0, 0, 0); set_m0(0, 0, 0, 0);
    tick(); tick();

    // 2a: conflict with data priority, M0 after M1 drops plus one idle cycle
    set_m0(0, 1, 1, 32'h200); set_m1(0, 1, 1, 0, 4'hF, 32'h300, 0); tick();
    chk("t2_first_d", 0, s_adr[0], 32'h300);
    set_sl(0, 1, 0, 32'h55); tick();
    set_sl(0, 0, 0, 0); set_m1(0, 0, 0, 0, 0, 0, 0); tick();
    chk("t2_idle_gap", 0, 32'(s_cyc[0]), 0);
    tick();
    chk("t2_then_i_adr", 0, s_adr[0], 32'h200);
    chk("t2_then_i_cyc", 0, 32'(s_cyc[0]), 1);
    set_sl(0, 1, 0, 32'h66); tick();
    set_sl(0, 0, 0, 0); set_m0(0, 0, 0, 0); tick(); tick();

    // 3: data write passes through while M0 waits
    set_m0(0, 1, 1, 32'h200); set_m1(0, 1, 1, 1, 4'b0011, 32'h2000_0004, 32'hDEAD_BEEF); tick();
    chk("t3_we", 0, 32'(s_we[0]), 1);
    chk("t3_sel", 0, 32'(s_sel[0]), 32'h3);
    chk("t3_dat", 0, s_wdat[0], 32'hDEAD_BEEF);
    chk("t3_adr", 0, s_adr[0], 32'h2000_0004);
    tick(); set_sl(0, 1, 0, 0); tick();
    set_sl(0, 0, 0, 0); set_m1(0, 1, 0, 1, 4'b0011, 32'h2000_0004, 32'hDEAD_BEEF);
    tick(); tick();
    chk("t3_m0_wait", 0, s_adr[0], 32'h2000_0004);
    chk("t3_m0_no_ack", 0, 32'(m0_ack[0]), 0);
    set_m1(0, 0, 0, 0, 0, 0, 0); tick(); tick();
    chk("t3_m0_granted", 0, s_adr[0], 32'h200);
    set_sl(0, 1, 0, 0); tick();
    set_sl(0, 0, 0, 0); set_m0(0, 0, 0, 0); tick(); tick();

    // 4: silent slave on M1 times out after TMO cycles
    set_m0(0, 1, 1, 32'h200); set_m1(0, 1, 1, 0, 4'hF, 32'h400, 0); tick();
    n = 0;
    while (m1_err[0] !== 1'b1 && n < 16) begin tick(); n++; end
    chk("t4_err_delay", 0, n, 8);
    tick();
    chk("t4_err_width", 0, 32'(m1_err[0]), 0);
    chk("t4_s_cyc_drop", 0, 32'(s_cyc[0]), 0);
    set_m1(0, 0, 0, 0, 0, 0, 0); tick();
    chk("t4_m0_wins", 0, s_adr[0], 32'h200);
    set_sl(0, 1, 0, 0); tick();
    set_sl(0, 0, 0, 0); set_m0(0, 0, 0, 0); tick(); tick();

    // 5: ack lands exactly on the timeout cycle
    set_m1(0, 1, 1, 0, 4'hF, 32'h500, 0); tick();
    repeat (8) tick();
    set_sl(0, 1, 0, 32'h77); #1;
    chk("t5_ack", 0, 32'(m1_ack[0]), 1);
    chk("t5_no_err", 0, 32'(m1_err[0]), 0);
    tick(); set_sl(0, 0, 0, 0);
    n = 0;
    while (m1_err[0] !== 1'b1 && n < 16) begin tick(); n++; end
    chk("t5_restart", 0, n, 8);
    set_m1(0, 0, 0, 0, 0, 0, 0); tick(); tick();

    // 2b: round-robin alternation over three conflicts
    for (int i = 0; i < 3; i++) begin
      set_m0(1, 1, 1, 32'h200); set_m1(1, 1, 1, 0, 4'hF, 32'h300, 0); tick();
      got[i] = s_adr[1];
      set_m0(1, 0, 0, 0); set_m1(1, 0, 0, 0, 0, 0, 0); tick();
    end
    chk("t2_rr_0", 1, got[0], 32'h200);
    chk("t2_rr_1", 1, got[1], 32'h300);
    chk("t2_rr_2", 1, got[2], 32'h200);

    // 6: async reset during an active data grant
    set_m0(1, 1, 1, 32'h200); set_m1(1, 1, 1, 0, 4'hF, 32'h300, 0); set_sl(1, 1, 0, 32'h99); tick();
    #1;
    chk("t6_pre_ack", 1, 32'(m1_ack[1]), 1);
    chk("t6_pre_stb", 1, 32'(s_stb[1]), 1);
    #1 rst_n[1] = 1'b0;
    #1;
    chk("t6_async_ctl", 1, 32'({s_cyc[1], s_stb[1], s_we[1], s_sel[1],
                               m0_ack[1], m0_err[1], m1_ack[1], m1_err[1]}), 0);
    chk("t6_async_adr", 1, s_adr[1], 0);
    chk("t6_async_dat", 1, m1_dat[1], 0);
    tick(); set_sl(1, 0, 0, 0); tick();
    rst_n[1] = 1'b1; tick();
    chk("t6_after_rst_m0", 1, s_adr[1], 32'h200);
    set_m0(1, 0, 0, 0); set_m1(1, 0, 0, 0, 0, 0, 0); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
